// File: rtl/ppu_bg_fetcher.sv
// Background/window tile fetcher: walks the tile map for the current line, reads
// index + both bit-planes from VRAM and pushes 8 decoded pixels into the BG FIFO.
module ppu_bg_fetcher #(
  parameter int FIFO_DEPTH = 8,
  parameter int PIXEL_W    = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  // regs byte lanes: [7:0] LCDC, [15:8] SCX, [23:16] SCY, [31:24] LY, [39:32] WX, [47:40] WY
  input  logic [47:0]                     regs,
  input  logic [1:0]                      mode,
  input  logic                            stall,
  input  logic [7:0]                      pixel_x,
  output logic                            read_req,
  output logic [15:0]                     addr,
  input  logic [7:0]                      rdata,
  output logic                            fifo_write_en,
  output logic [FIFO_DEPTH*PIXEL_W-1:0]   fifo_write_data,
  input  logic                            fifo_empty,
  output logic                            fifo_clear
);

  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_DRAW   = 2'd3;

  typedef enum logic [2:0] {IDLE, TILE0, TILE1, LO0, LO1, HI0, HI1, PUSH} state_t;

  state_t      state;
  logic [4:0]  fetch_x;
  logic [7:0]  win_line;
  logic        window_active;
  logic [7:0]  lo_byte;

  logic [7:0]  lcdc, scx, scy, ly, wx, wy;
  logic [7:0]  bg_line;
  logic        in_draw;
  logic        window_hit;
  logic        trigger;
  logic        unused_reg_bits;

  assign lcdc = regs[7:0];
  assign scx  = regs[15:8];
  assign scy  = regs[23:16];
  assign ly   = regs[31:24];
  assign wx   = regs[39:32];
  assign wy   = regs[47:40];
  assign unused_reg_bits = ^{lcdc[7], lcdc[2:0], scx[2:0]};

  assign bg_line    = ly + scy;
  assign in_draw    = (mode == MODE_DRAW);
  // 9-bit compare so pixel_x + 7 cannot wrap past WX
  assign window_hit = lcdc[5] && (ly >= wy) && (({1'b0, pixel_x} + 9'd7) >= {1'b0, wx});
  assign trigger    = in_draw && !stall && (state != IDLE) && window_hit && !window_active;

  assign read_req      = in_draw && !stall && (state == TILE0 || state == LO0 || state == HI0);
  assign fifo_write_en = in_draw && !stall && (state == PUSH) && fifo_empty && !trigger;

  // Map base bits {10011, sel} give 0x9800 / 0x9C00; low 10 bits are ty*32 + tx.
  function automatic logic [15:0] map_addr(input logic win, input logic [4:0] fx);
    logic [4:0] tx;
    logic [4:0] ty;
    logic       base_sel;
    if (win) begin
      tx       = fx;
      ty       = win_line[7:3];
      base_sel = lcdc[6];
    end else begin
      tx       = scx[7:3] + fx;
      ty       = bg_line[7:3];
      base_sel = lcdc[3];
    end
    return {5'b10011, base_sel, ty, tx};
  endfunction

  function automatic logic [15:0] data_addr(input logic [7:0] idx, input logic win);
    logic [2:0]  row;
    logic [15:0] base;
    logic [15:0] offset;
    row = win ? win_line[2:0] : bg_line[2:0];
    if (lcdc[4]) begin
      base   = 16'h8000;
      offset = {4'b0000, idx, 4'b0000};
    end else begin
      base   = 16'h9000;
      offset = {{4{idx[7]}}, idx, 4'b0000};
    end
    return base + offset + {12'd0, row, 1'b0};
  endfunction

  function automatic logic [FIFO_DEPTH*PIXEL_W-1:0] decode(input logic [7:0] lo, input logic [7:0] hi);
    logic [FIFO_DEPTH*PIXEL_W-1:0] px;
    px = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      px[i*PIXEL_W +: 2] = {hi[7-i], lo[7-i]};
    end
    return px;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      addr            <= '0;
      fifo_write_data <= '0;
      fifo_clear      <= 1'b0;
      fetch_x         <= '0;
      win_line        <= '0;
      window_active   <= 1'b0;
      lo_byte         <= '0;
    end else begin
      fifo_clear <= 1'b0;
      if (!in_draw) begin
        state <= IDLE;
        if (mode == MODE_VBLANK) begin
          win_line <= '0;
        end else if (state != IDLE && window_active) begin
          win_line <= win_line + 8'd1;
        end
      end else if (!stall) begin
        if (state == IDLE) begin
          state         <= TILE0;
          fetch_x       <= '0;
          window_active <= 1'b0;
          addr          <= map_addr(1'b0, 5'd0);
        end else if (trigger) begin
          // Drop whatever was in flight and restart on the window map
          state         <= TILE0;
          fetch_x       <= '0;
          window_active <= 1'b1;
          fifo_clear    <= 1'b1;
          addr          <= map_addr(1'b1, 5'd0);
        end else begin
          case (state)
            TILE0: state <= TILE1;
            TILE1: begin
              addr  <= data_addr(rdata, window_active);
              state <= LO0;
            end
            LO0:   state <= LO1;
            LO1: begin
              lo_byte <= rdata;
              addr    <= addr + 16'd1;
              state   <= HI0;
            end
            HI0:   state <= HI1;
            HI1: begin
              fifo_write_data <= decode(lo_byte, rdata);
              state           <= PUSH;
            end
            PUSH: begin
              if (fifo_empty) begin
                fetch_x <= fetch_x + 5'd1;
                addr    <= map_addr(window_active, fetch_x + 5'd1);
                state   <= TILE0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ppu_bg_fetcher.sv
// Scenario bench for ppu_bg_fetcher; expected addresses and pixels come from
// a transaction-level model of the tile-map / tile-data rules.
`timescale 1ns/1ps
module tb_ppu_bg_fetcher;

  localparam logic [1:0] HBLANK = 2'd0;
  localparam logic [1:0] VBLANK = 2'd1;
  localparam logic [1:0] DRAW   = 2'd3;

  logic        clk;
  logic        reset_n;
  logic [47:0] regs;
  logic [1:0]  mode;
  logic        stall;
  logic [7:0]  pixel_x;
  logic        read_req;
  logic [15:0] addr;
  logic [7:0]  rdata;
  logic        fifo_write_en;
  logic [63:0] fifo_write_data;
  logic        fifo_empty;
  logic        fifo_clear;

  logic [7:0]  lcdc, scx, scy, ly, wx, wy;
  assign regs = {wy, wx, ly, scy, scx, lcdc};

  int total = 0;
  int bad   = 0;

  logic [7:0] vram [0:65535];

  typedef struct {
    bit          rr;
    logic [15:0] a;
    bit          we;
    logic [63:0] wd;
    bit          fc;
    bit          st;
    bit          fe;
  } obs_t;
  obs_t obs[$];
  bit   rec = 0;

  ppu_bg_fetcher dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .regs            (regs),
    .mode            (mode),
    .stall           (stall),
    .pixel_x         (pixel_x),
    .read_req        (read_req),
    .addr            (addr),
    .rdata           (rdata),
    .fifo_write_en   (fifo_write_en),
    .fifo_write_data (fifo_write_data),
    .fifo_empty      (fifo_empty),
    .fifo_clear      (fifo_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM: data appears the cycle after the strobe
  always @(posedge clk) if (read_req) rdata <= vram[addr];

  always @(negedge clk)
    if (rec) obs.push_back('{read_req, addr, fifo_write_en, fifo_write_data, fifo_clear, stall, fifo_empty});

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] m_map(input int fx, input bit win, input int wl);
    int base, tx, ty;
    if (win) begin
      base = lcdc[6] ? 'h9C00 : 'h9800;
      tx   = fx % 32;
      ty   = wl / 8;
    end else begin
      base = lcdc[3] ? 'h9C00 : 'h9800;
      tx   = (int'(scx) / 8 + fx) % 32;
      ty   = ((int'(ly) + int'(scy)) % 256) / 8;
    end
    return 16'(base + ty * 32 + tx);
  endfunction

  function automatic logic [15:0] m_lo(input logic [7:0] idx, input int line);
    int a, sidx;
    sidx = (idx >= 8'd128) ? int'(idx) - 256 : int'(idx);
    if (lcdc[4]) a = 'h8000 + int'(idx) * 16 + 2 * (line % 8);
    else         a = 'h9000 + sidx * 16 + 2 * (line % 8);
    return 16'(a);
  endfunction

  function automatic logic [63:0] m_px(input logic [7:0] lo, input logic [7:0] hi);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      p[i*8 +: 8] = 8'(((int'(hi) >> (7 - i)) & 1) * 2 + ((int'(lo) >> (7 - i)) & 1));
    return p;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic begin_draw();
    obs.delete();
    @(posedge clk); #1;
    mode = DRAW;
    rec  = 1;
  endtask

  task automatic end_draw();
    @(negedge clk); #1;
    rec = 0;
    @(posedge clk); #1;
    mode = HBLANK;
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0; mode = HBLANK; stall = 1'b0; fifo_empty = 1'b1; pixel_x = 8'd0;
    lcdc = 8'h00; scx = 8'h00; scy = 8'h00; ly = 8'h00; wx = 8'h00; wy = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (read_req !== 1'b0) begin bad++; $display("FAIL reset_read_req got=%0b want=0", read_req); end
    total++; if (addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h want=0000", addr); end
    total++; if (fifo_write_en !== 1'b0) begin bad++; $display("FAIL reset_write_en got=%0b want=0", fifo_write_en); end
    total++; if (fifo_write_data !== 64'd0) begin bad++; $display("FAIL reset_write_data got=%h want=0", fifo_write_data); end
    total++; if (fifo_clear !== 1'b0) begin bad++; $display("FAIL reset_fifo_clear got=%0b want=0", fifo_clear); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    next_cycle();
    $display("reset checked");
  endtask

  task automatic test_basic();
    bit want;
    lcdc = 8'h91; scx = 8'h00; scy = 8'h00; ly = 8'h00; fifo_empty = 1'b1; stall = 1'b0;
    vram[16'h9800] = 8'h01; vram[16'h8010] = 8'h3C; vram[16'h8011] = 8'h7E;
    begin_draw();
    repeat (7) next_cycle();
    end_draw();
    for (int c = 0; c < 8; c++) begin
      want = (c == 1 || c == 3 || c == 5);
      total++; if (obs[c].rr !== want) begin bad++; $display("FAIL basic_read_req cycle=%0d got=%0b want=%0b", c, obs[c].rr, want); end
      want = (c == 7);
      total++; if (obs[c].we !== want) begin bad++; $display("FAIL basic_write_en cycle=%0d got=%0b want=%0b", c, obs[c].we, want); end
    end
    total++; if (obs[1].a !== 16'h9800) begin bad++; $display("FAIL basic_map_addr got=%h want=9800", obs[1].a); end
    total++; if (obs[3].a !== 16'h8010) begin bad++; $display("FAIL basic_lo_addr got=%h want=8010", obs[3].a); end
    total++; if (obs[5].a !== 16'h8011) begin bad++; $display("FAIL basic_hi_addr got=%h want=8011", obs[5].a); end
    total++; if (obs[7].wd !== 64'h0002030303030200) begin bad++; $display("FAIL basic_pixels got=%h want=0002030303030200", obs[7].wd); end
    $display("basic push data=%h", obs[7].wd);
  endtask

  task automatic test_signed();
    lcdc = 8'h81; scx = 8'h00; scy = 8'h00; ly = 8'd3;
    vram[16'h9800] = 8'h80;
    begin_draw();
    repeat (7) next_cycle();
    end_draw();
    total++; if (obs[3].a !== 16'h8806) begin bad++; $display("FAIL signed_lo_addr got=%h want=8806", obs[3].a); end
    total++; if (obs[5].a !== 16'h8807) begin bad++; $display("FAIL signed_hi_addr got=%h want=8807", obs[5].a); end
    $display("signed lo=%h hi=%h", obs[3].a, obs[5].a);
  endtask

  task automatic test_scroll();
    lcdc = 8'h91; scx = 8'h10; scy = 8'h0A; ly = 8'h07;
    vram[16'h9842] = 8'h21;
    begin_draw();
    repeat (7) next_cycle();
    end_draw();
    total++; if (obs[1].a !== 16'h9842) begin bad++; $display("FAIL scroll_map_addr got=%h want=9842", obs[1].a); end
    total++; if (obs[3].a !== 16'h8212) begin bad++; $display("FAIL scroll_lo_addr got=%h want=8212", obs[3].a); end
    total++; if (obs[5].a !== 16'h8213) begin bad++; $display("FAIL scroll_hi_addr got=%h want=8213", obs[5].a); end
    $display("scroll map=%h lo=%h", obs[1].a, obs[3].a);
  endtask

  task automatic test_backpressure();
    bit          want;
    logic [15:0] m, lo;
    lcdc = 8'h91; scx = 8'h00; scy = 8'h00; ly = 8'h00; fifo_empty = 1'b0; stall = 1'b0;
    begin_draw();
    for (int n = 1; n < 24; n++) begin
      next_cycle();
      fifo_empty = (n >= 12);
      stall      = (n >= 15 && n <= 18);
    end
    end_draw();
    stall = 1'b0; fifo_empty = 1'b1;
    m  = m_map(1, 1'b0, 0);
    lo = m_lo(vram[m], 0);
    for (int c = 0; c < 24; c++) begin
      want = (c == 1 || c == 3 || c == 5 || c == 13 || c == 19 || c == 21);
      total++; if (obs[c].rr !== want) begin bad++; $display("FAIL bp_read_req cycle=%0d got=%0b want=%0b", c, obs[c].rr, want); end
      want = (c == 12 || c == 23);
      total++; if (obs[c].we !== want) begin bad++; $display("FAIL bp_write_en cycle=%0d got=%0b want=%0b", c, obs[c].we, want); end
    end
    total++; if (obs[13].a !== m) begin bad++; $display("FAIL bp_map_addr got=%h want=%h", obs[13].a, m); end
    total++; if (obs[19].a !== lo) begin bad++; $display("FAIL bp_lo_reissue got=%h want=%h", obs[19].a, lo); end
    total++; if (obs[21].a !== lo + 16'd1) begin bad++; $display("FAIL bp_hi_addr got=%h want=%h", obs[21].a, lo + 16'd1); end
    total++; if (obs[23].wd !== m_px(vram[lo], vram[lo + 16'd1])) begin
      bad++; $display("FAIL bp_pixels got=%h want=%h", obs[23].wd, m_px(vram[lo], vram[lo + 16'd1]));
    end
    $display("backpressure push data=%h", obs[23].wd);
  endtask

  task automatic test_window();
    bit          want;
    logic [15:0] lo;
    int          both;
    lcdc = 8'hF1; scx = 8'h00; scy = 8'h00; ly = 8'h00; wy = 8'h00; wx = 8'd7; pixel_x = 8'd0;
    fifo_empty = 1'b1; stall = 1'b0;
    mode = VBLANK; next_cycle();
    mode = HBLANK; next_cycle();
    vram[16'h9C00] = 8'h05;
    for (int line = 0; line < 2; line++) begin
      ly = 8'(line);
      begin_draw();
      repeat (11) next_cycle();
      end_draw();
      lo   = m_lo(8'h05, line);
      both = 0;
      for (int c = 0; c < 12; c++) begin
        want = (c == 2);
        total++; if (obs[c].fc !== want) begin bad++; $display("FAIL win_fifo_clear line=%0d cycle=%0d got=%0b want=%0b", line, c, obs[c].fc, want); end
        if (obs[c].fc && obs[c].we) both++;
      end
      total++; if (both != 0) begin bad++; $display("FAIL win_clear_with_write line=%0d got=%0d want=0", line, both); end
      total++; if (obs[2].rr !== 1'b1 || obs[2].a !== m_map(0, 1'b1, line)) begin
        bad++; $display("FAIL win_map_read line=%0d got=%0b/%h want=1/%h", line, obs[2].rr, obs[2].a, m_map(0, 1'b1, line));
      end
      total++; if (obs[4].a !== lo) begin bad++; $display("FAIL win_lo_addr line=%0d got=%h want=%h", line, obs[4].a, lo); end
      total++; if (obs[8].we !== 1'b1 || obs[8].wd !== m_px(vram[lo], vram[lo + 16'd1])) begin
        bad++; $display("FAIL win_push line=%0d got=%0b/%h want=1/%h", line, obs[8].we, obs[8].wd, m_px(vram[lo], vram[lo + 16'd1]));
      end
      $display("window line=%0d lo=%h", line, obs[4].a);
    end
    lcdc = 8'h91;
  endtask

  task automatic test_reset_mid();
    bit want;
    lcdc = 8'h91; scx = 8'h00; scy = 8'h00; ly = 8'h00; fifo_empty = 1'b1; stall = 1'b0;
    vram[16'h9800] = 8'h01;
    begin_draw();
    repeat (6) next_cycle();
    reset_n = 1'b0;
    @(negedge clk);
    total++; if (read_req !== 1'b0) begin bad++; $display("FAIL rstmid_read_req got=%0b want=0", read_req); end
    total++; if (addr !== 16'h0000) begin bad++; $display("FAIL rstmid_addr got=%h want=0000", addr); end
    total++; if (fifo_write_data !== 64'd0) begin bad++; $display("FAIL rstmid_write_data got=%h want=0", fifo_write_data); end
    total++; if (fifo_clear !== 1'b0) begin bad++; $display("FAIL rstmid_fifo_clear got=%0b want=0", fifo_clear); end
    next_cycle();
    @(negedge clk);
    total++; if (fifo_write_en !== 1'b0) begin bad++; $display("FAIL rstmid_write_en got=%0b want=0", fifo_write_en); end
    rec = 0;
    next_cycle();
    obs.delete();
    reset_n = 1'b1;
    rec = 1;
    repeat (7) next_cycle();
    end_draw();
    for (int c = 0; c < 8; c++) begin
      want = (c == 1 || c == 3 || c == 5);
      total++; if (obs[c].rr !== want) begin bad++; $display("FAIL rstmid_restart_rr cycle=%0d got=%0b want=%0b", c, obs[c].rr, want); end
    end
    total++; if (obs[1].a !== 16'h9800) begin bad++; $display("FAIL rstmid_map_addr got=%h want=9800", obs[1].a); end
    total++; if (obs[7].we !== 1'b1 || obs[7].wd !== 64'h0002030303030200) begin
      bad++; $display("FAIL rstmid_push got=%0b/%h want=1/0002030303030200", obs[7].we, obs[7].wd);
    end
    $display("reset mid-fetch restart data=%h", obs[7].wd);
  endtask

  task automatic test_random();
    logic [15:0] exp_reads[$];
    logic [15:0] m, lo;
    int          nr, np, viol, line;
    for (int it = 0; it < 20; it++) begin
      lcdc = (8'($urandom) & 8'hDF) | 8'h81;
      scx  = 8'($urandom);
      scy  = 8'($urandom);
      ly   = 8'($urandom_range(0, 143));
      begin_draw();
      stall      = ($urandom_range(0, 3) == 0);
      fifo_empty = ($urandom_range(0, 2) != 0);
      for (int n = 1; n < 64; n++) begin
        next_cycle();
        stall      = ($urandom_range(0, 3) == 0);
        fifo_empty = ($urandom_range(0, 2) != 0);
      end
      end_draw();
      stall = 1'b0; fifo_empty = 1'b1;
      line = (int'(ly) + int'(scy)) % 256;
      exp_reads.delete();
      for (int k = 0; k < 10; k++) begin
        m  = m_map(k, 1'b0, 0);
        lo = m_lo(vram[m], line);
        exp_reads.push_back(m);
        exp_reads.push_back(lo);
        exp_reads.push_back(lo + 16'd1);
      end
      nr = 0; np = 0; viol = 0;
      foreach (obs[c]) begin
        if (obs[c].rr) begin
          total++;
          if (nr >= exp_reads.size() || obs[c].a !== exp_reads[nr]) begin
            bad++; $display("FAIL rand_read it=%0d n=%0d got=%h want=%h", it, nr, obs[c].a, (nr < exp_reads.size()) ? exp_reads[nr] : 16'hxxxx);
          end
          nr++;
        end
        if (obs[c].we) begin
          lo = exp_reads[np * 3 + 1];
          total++;
          if (obs[c].wd !== m_px(vram[lo], vram[lo + 16'd1])) begin
            bad++; $display("FAIL rand_push it=%0d tile=%0d got=%h want=%h", it, np, obs[c].wd, m_px(vram[lo], vram[lo + 16'd1]));
          end
          np++;
        end
        if ((obs[c].rr && obs[c].st) || (obs[c].we && (obs[c].st || !obs[c].fe)) || obs[c].fc) viol++;
      end
      total++; if (viol != 0) begin bad++; $display("FAIL rand_protocol it=%0d got=%0d violations want=0", it, viol); end
      total++; if (np < 1) begin bad++; $display("FAIL rand_progress it=%0d got=%0d pushes want>=1", it, np); end
      $display("random it=%0d lcdc=%h scx=%h scy=%h ly=%0d reads=%0d pushes=%0d", it, lcdc, scx, scy, ly, nr, np);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) vram[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_signed();
    test_scroll();
    test_backpressure();
    test_window();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
